// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - interrupt entry/exit sequencer driving the memory-stage stack and fetch redirect
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0002,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    input  logic        mem_ready,
    input  logic [15:0] pop_data,
    output logic        push_req,
    output logic [15:0] push_data,
    output logic        pop_req,
    output logic [1:0]  counter,
    output logic        int_active,
    output logic        fetch_stall,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        ccr_load,
    output logic [2:0]  ccr_out
);

    typedef enum logic [3:0] {
        IDLE,
        DRAIN,
        PUSH_PC_H,
        PUSH_PC_L,
        PUSH_FLAGS,
        VECTOR,
        POP_FLAGS,
        POP_PC_L,
        POP_PC_H,
        RESUME
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 3'(DRAIN_CYCLES - 1) : 3'd0;

    state_t      r_state;
    logic        r_int_req_d;
    logic        r_armed;
    logic        r_pending;
    logic [31:0] r_pc_sv;
    logic [2:0]  r_ccr_sv;
    logic [2:0]  r_drain_cnt;
    logic [15:0] r_rs_pc_h;
    logic [15:0] r_rs_pc_l;
    logic [2:0]  r_rs_ccr;
    logic        w_event;

    // r_armed masks the first cycle after reset, so a request already high
    // when reset releases is not mistaken for a fresh rising edge.
    assign w_event = int_req & ~r_int_req_d & r_armed;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_int_req_d <= 1'b0;
            r_armed     <= 1'b0;
            r_pending   <= 1'b0;
            r_pc_sv     <= 32'd0;
            r_ccr_sv    <= 3'd0;
            r_drain_cnt <= 3'd0;
            r_rs_pc_h   <= 16'd0;
            r_rs_pc_l   <= 16'd0;
            r_rs_ccr    <= 3'd0;
        end else begin
            r_int_req_d <= int_req;
            r_armed     <= 1'b1;
            if (r_state != IDLE && w_event) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (rti_req) begin
                        r_state <= POP_FLAGS;
                        if (w_event) begin
                            r_pending <= 1'b1;
                        end
                    end else if (w_event || r_pending) begin
                        r_state     <= (DRAIN_CYCLES == 0) ? PUSH_PC_H : DRAIN;
                        r_pc_sv     <= pc_in;
                        r_ccr_sv    <= ccr_in;
                        r_pending   <= 1'b0;
                        r_drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == 3'd0) begin
                        r_state <= PUSH_PC_H;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end
                PUSH_PC_H:  if (mem_ready) r_state <= PUSH_PC_L;
                PUSH_PC_L:  if (mem_ready) r_state <= PUSH_FLAGS;
                PUSH_FLAGS: if (mem_ready) r_state <= VECTOR;
                VECTOR:     r_state <= IDLE;
                POP_FLAGS: begin
                    if (mem_ready) begin
                        r_rs_ccr <= pop_data[2:0];
                        r_state  <= POP_PC_L;
                    end
                end
                POP_PC_L: begin
                    if (mem_ready) begin
                        r_rs_pc_l <= pop_data;
                        r_state   <= POP_PC_H;
                    end
                end
                POP_PC_H: begin
                    if (mem_ready) begin
                        r_rs_pc_h <= pop_data;
                        r_state   <= RESUME;
                    end
                end
                RESUME:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are a pure decode of the registered state and saved words.
    always_comb begin
        push_req    = 1'b0;
        push_data   = 16'd0;
        pop_req     = 1'b0;
        counter     = 2'd0;
        int_active  = (r_state != IDLE);
        fetch_stall = (r_state != IDLE);
        jump_en     = 1'b0;
        jump_addr   = 32'd0;
        ccr_load    = 1'b0;
        ccr_out     = 3'd0;
        case (r_state)
            PUSH_PC_H: begin
                push_req  = 1'b1;
                push_data = r_pc_sv[31:16];
                counter   = 2'd1;
            end
            PUSH_PC_L: begin
                push_req  = 1'b1;
                push_data = r_pc_sv[15:0];
                counter   = 2'd2;
            end
            PUSH_FLAGS: begin
                push_req  = 1'b1;
                push_data = {13'd0, r_ccr_sv};
                counter   = 2'd3;
            end
            VECTOR: begin
                jump_en   = 1'b1;
                jump_addr = VECTOR_ADDR;
            end
            POP_FLAGS: begin
                pop_req = 1'b1;
                counter = 2'd3;
            end
            POP_PC_L: begin
                pop_req = 1'b1;
                counter = 2'd2;
            end
            POP_PC_H: begin
                pop_req = 1'b1;
                counter = 2'd1;
            end
            RESUME: begin
                jump_en   = 1'b1;
                jump_addr = {r_rs_pc_h, r_rs_pc_l};
                ccr_load  = 1'b1;
                ccr_out   = r_rs_ccr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - bench for interrupt_sequencer against a step-queue reference model
module tb_interrupt_sequencer;

    localparam logic [31:0] VEC   = 32'h0000_0002;
    localparam int          DRAIN = 3;

    localparam logic [2:0] K_STALL = 3'd0;
    localparam logic [2:0] K_PUSH  = 3'd1;
    localparam logic [2:0] K_POP   = 3'd2;
    localparam logic [2:0] K_VEC   = 3'd3;
    localparam logic [2:0] K_RES   = 3'd4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        int_req;
    logic        rti_req;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic        mem_ready;
    logic [15:0] pop_data;
    logic        push_req;
    logic [15:0] push_data;
    logic        pop_req;
    logic [1:0]  counter;
    logic        int_active;
    logic        fetch_stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        ccr_load;
    logic [2:0]  ccr_out;

    int checks   = 0;
    int failures = 0;

    interrupt_sequencer #(.VECTOR_ADDR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .RESET(RESET), .int_req(int_req), .rti_req(rti_req),
        .pc_in(pc_in), .ccr_in(ccr_in), .mem_ready(mem_ready), .pop_data(pop_data),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req), .counter(counter),
        .int_active(int_active), .fetch_stall(fetch_stall), .jump_en(jump_en),
        .jump_addr(jump_addr), .ccr_load(ccr_load), .ccr_out(ccr_out)
    );

    always #5 clk = ~clk;

    // The model sees a sequence as a queue of steps; the head step is what the outputs show.
    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  cnt;
        logic [15:0] data;
    } step_t;

    step_t       m_q[$];
    bit          m_pending;
    bit          m_prev;
    bit          m_armed;
    bit          m_valid = 1'b0;
    logic [15:0] m_w[1:3];

    function automatic step_t mk(input logic [2:0] k, input logic [1:0] c, input logic [15:0] d);
        step_t s;
        s.kind = k;
        s.cnt  = c;
        s.data = d;
        return s;
    endfunction

    function automatic logic [58:0] dut_vec();
        return {push_req, push_data, pop_req, counter, int_active, fetch_stall,
                jump_en, jump_addr, ccr_load, ccr_out};
    endfunction

    function automatic logic [58:0] model_vec();
        logic        pr, por, je, cl;
        logic [15:0] pd;
        logic [1:0]  c;
        logic [31:0] ja;
        logic [2:0]  co;
        step_t       s;
        pr = 0; por = 0; je = 0; cl = 0; pd = 0; c = 0; ja = 0; co = 0;
        if (m_q.size() == 0) return 59'd0;
        s = m_q[0];
        case (s.kind)
            K_PUSH: begin pr = 1; pd = s.data; c = s.cnt; end
            K_POP:  begin por = 1; c = s.cnt; end
            K_VEC:  begin je = 1; ja = VEC; end
            K_RES:  begin je = 1; ja = {m_w[1], m_w[2]}; cl = 1; co = m_w[3][2:0]; end
            default: ;
        endcase
        return {pr, pd, por, c, 1'b1, 1'b1, je, ja, cl, co};
    endfunction

    always @(posedge clk) begin : model
        bit ev;
        if (RESET) begin
            m_q.delete();
            m_pending = 0;
            m_prev    = 0;
            m_armed   = 0;
            m_valid   = 1;
        end else begin
            ev      = int_req && !m_prev && m_armed;
            m_prev  = int_req;
            m_armed = 1;
            if (m_q.size() == 0) begin
                if (rti_req) begin
                    if (ev) m_pending = 1;
                    m_q.push_back(mk(K_POP, 2'd3, 16'd0));
                    m_q.push_back(mk(K_POP, 2'd2, 16'd0));
                    m_q.push_back(mk(K_POP, 2'd1, 16'd0));
                    m_q.push_back(mk(K_RES, 2'd0, 16'd0));
                end else if (ev || m_pending) begin
                    m_pending = 0;
                    for (int i = 0; i < DRAIN; i++) m_q.push_back(mk(K_STALL, 2'd0, 16'd0));
                    m_q.push_back(mk(K_PUSH, 2'd1, pc_in[31:16]));
                    m_q.push_back(mk(K_PUSH, 2'd2, pc_in[15:0]));
                    m_q.push_back(mk(K_PUSH, 2'd3, {13'd0, ccr_in}));
                    m_q.push_back(mk(K_VEC, 2'd0, 16'd0));
                end
            end else begin
                if (ev) m_pending = 1;
                if (m_q[0].kind == K_PUSH || m_q[0].kind == K_POP) begin
                    if (mem_ready) begin
                        if (m_q[0].kind == K_POP) m_w[m_q[0].cnt] = pop_data;
                        void'(m_q.pop_front());
                    end
                end else begin
                    void'(m_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [58:0] exp_v, got_v;
            exp_v = model_vec();
            got_v = dut_vec();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        RESET = 1; int_req = 1; rti_req = 0; pc_in = 0; ccr_in = 0; mem_ready = 1; pop_data = 0;
        tick(); tick();
        chk("reset_outputs", {5'd0, dut_vec()} == 64'd0, 1);
        RESET = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_trigger_after_reset", int_active, 0);
        end
        int_req = 0;
        tick();

        // interrupt entry, cycle 0 below
        pc_in = 32'h0001_0A3C; ccr_in = 3'b101; int_req = 1;
        tick(); chk("drain_c1_stall", fetch_stall, 1); chk("drain_c1_push", push_req, 0);
        tick(); tick(); chk("drain_c3_push", push_req, 0);
        tick(); chk("push_h", {push_req, counter, push_data}, {1'b1, 2'd1, 16'h0001});
        tick(); chk("push_l", {push_req, counter, push_data}, {1'b1, 2'd2, 16'h0A3C});
        tick(); chk("push_f", {push_req, counter, push_data}, {1'b1, 2'd3, 16'h0005});
        tick(); chk("vector_jump", {jump_en, push_req}, 2'b10); chk("vector_addr", jump_addr, 32'h2);
        tick(); chk("entry_idle", {int_active, jump_en}, 2'b00);
        int_req = 0;
        tick();

        // handshake stall on PUSH_PC_L
        int_req = 1;
        for (int i = 0; i < 4; i++) tick();
        tick(); mem_ready = 0; chk("hold_c5", push_data, 16'h0A3C);
        tick(); chk("hold_c6", {push_req, push_data}, {1'b1, 16'h0A3C});
        tick(); mem_ready = 1; chk("hold_c7", push_data, 16'h0A3C);
        tick(); chk("hold_flags_c8", counter, 3);
        tick(); chk("hold_vector_c9", jump_en, 1);
        tick(); int_req = 0;
        tick();

        // RTI
        rti_req = 1;
        tick(); rti_req = 0; pop_data = 16'h0005; chk("pop_flags", {pop_req, counter}, 3'b111);
        tick(); pop_data = 16'h0A3C; chk("pop_l", counter, 2);
        tick(); pop_data = 16'h0001; chk("pop_h", counter, 1);
        tick(); chk("resume_addr", jump_addr, 32'h0001_0A3C);
        chk("resume_ccr", {jump_en, ccr_load, ccr_out}, 5'b11101);
        tick(); chk("resume_done", {ccr_load, ccr_out, jump_addr}, 0);

        // event during PUSH_PC_L stays pending until after VECTOR
        int_req = 1;
        tick(); tick(); int_req = 0;
        tick(); tick(); tick(); int_req = 1;
        tick(); tick(); chk("nest_vector", jump_en, 1);
        tick(); chk("nest_idle", int_active, 0);
        tick(); chk("nest_entry", {int_active, fetch_stall}, 2'b11);
        for (int i = 0; i < 7; i++) tick();
        chk("nest_done", int_active, 0);
        int_req = 0;
        tick();

        // RTI and event in the same IDLE cycle
        rti_req = 1; int_req = 1; pop_data = 16'h1234;
        tick(); rti_req = 0; chk("rti_prio", {pop_req, push_req, counter}, 4'b1011);
        tick(); tick(); tick(); chk("rti_prio_resume", ccr_load, 1);
        tick(); chk("rti_prio_idle", int_active, 0);
        tick(); chk("int_after_resume", int_active, 1);
        for (int i = 0; i < 7; i++) tick();
        chk("int_after_resume_done", int_active, 0);
        int_req = 0;
        tick();

        // reset during POP_PC_L
        rti_req = 1;
        tick(); rti_req = 0;
        tick(); chk("pre_reset_pop_l", counter, 2); RESET = 1;
        tick(); RESET = 0; chk("reset_mid", {5'd0, dut_vec()} == 64'd0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_mid_quiet", {int_active, jump_en}, 0);
        end

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(11) == 0) int_req = ~int_req;
            rti_req   = ($urandom_range(19) == 0);
            mem_ready = ($urandom_range(3) != 0);
            pop_data  = 16'($urandom);
            pc_in     = $urandom;
            ccr_in    = 3'($urandom);
            RESET     = ($urandom_range(499) == 0);
            tick();
        end
        RESET = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
